// File: rtl/basys3_calc_pkg.sv
// Shared definitions for the basys3 switch-programmed calculator:
// opcodes, instruction field positions, ASCII codes and UART TX states.
package basys3_calc_pkg;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_MULT = 2'b10;
   localparam logic [1:0] OP_SEND = 2'b11;

   localparam int unsigned OP_HI  = 7;
   localparam int unsigned OP_LO  = 6;
   localparam int unsigned RA_HI  = 5;
   localparam int unsigned RA_LO  = 4;
   localparam int unsigned RB_HI  = 3;
   localparam int unsigned RB_LO  = 2;
   localparam int unsigned RC_HI  = 1;
   localparam int unsigned RC_LO  = 0;
   localparam int unsigned IMM_HI = 3;
   localparam int unsigned IMM_LO = 0;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Uppercase ASCII hex digit for one nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] i_nib);
      return (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib}) : (8'h37 + {4'h0, i_nib});
   endfunction

endpackage

// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter, LSB first, CLK_HZ/BAUD clocks per bit.
// i_vld is accepted only while idle; o_busy is high for the whole frame.
module uart_tx
   import basys3_calc_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 1_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_vld,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_tx
);

   localparam int unsigned CPB = CLK_HZ / BAUD;
   localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;

   tx_state_t     r_state;
   tx_state_t     w_state_nxt;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          w_bit_end;

   assign w_bit_end = (r_baud_cnt == CW'(CPB - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= TX_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == TX_IDLE) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            if (i_vld) r_shift <= i_data;
         end else if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_state == TX_DATA) begin
               r_shift   <= r_shift >> 1;
               r_bit_idx <= r_bit_idx + 3'd1;
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_tx        = 1'b1;
      o_busy      = 1'b1;
      case (r_state)
         TX_IDLE: begin
            o_busy = 1'b0;
            if (i_vld) w_state_nxt = TX_START;
         end
         TX_START: begin
            o_tx = 1'b0;
            if (w_bit_end) w_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            o_tx = r_shift[0];
            if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = TX_STOP;
         end
         TX_STOP: begin
            if (w_bit_end) w_state_nxt = TX_IDLE;
         end
         default: w_state_nxt = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/basys3_top.sv
// Switch-programmed 4x8-bit register calculator: debounced btnS executes sw[7:0].
// Define SEND_HEX_EN to make SEND emit ASCII hex + CR LF instead of one raw byte.
module basys3_top
   import basys3_calc_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 1_000_000,
   parameter int unsigned DB_TICK    = 50_000,
   parameter int unsigned DB_SAMPLES = 2
) (
   input  logic       clk,
   input  logic       btnR,
   input  logic [7:0] sw,
   input  logic       btnS,
   input  logic       RsRx,
   output logic       RsTx,
   output logic [7:0] led
);

   localparam int unsigned TW  = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
   localparam int unsigned SCW = $clog2(DB_SAMPLES + 1);

   logic          w_unused_rx;
   logic [1:0]    r_btn_sync;
   logic [7:0]    r_sw_s1, r_sw_s2;
   logic [TW-1:0] r_tick_cnt;
   logic [SCW-1:0] r_db_cnt;
   logic          r_db_level;
   logic          w_tick, w_rise;
   logic          inst_vld;
   logic [7:0]    inst_wd;

   logic [7:0]    r_regs [4];
   logic [7:0]    r_led;
   logic [1:0]    w_op, w_ra, w_rb, w_rc;
   logic [3:0]    w_immd;
   logic [7:0]    w_ra_val, w_sum, w_prod, w_result;
   logic          w_send_go, w_send_busy;

   logic          r_tx_vld;
   logic [7:0]    r_tx_byte;
   logic          w_tx_busy;

   assign w_unused_rx = RsRx;
   assign led         = r_led;

   assign w_tick = (r_tick_cnt == TW'(DB_TICK - 1));
   // A rising debounced level is the last of DB_SAMPLES consecutive high samples.
   assign w_rise = w_tick && !r_db_level && r_btn_sync[1] && (r_db_cnt == SCW'(DB_SAMPLES - 1));

   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) begin
         r_btn_sync <= '0;
         r_sw_s1    <= '0;
         r_sw_s2    <= '0;
         r_tick_cnt <= '0;
         r_db_cnt   <= '0;
         r_db_level <= 1'b0;
         inst_vld   <= 1'b0;
         inst_wd    <= '0;
      end else begin
         r_btn_sync <= {r_btn_sync[0], btnS};
         r_sw_s1    <= sw;
         r_sw_s2    <= r_sw_s1;
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (w_tick) begin
            if (r_btn_sync[1] == r_db_level) begin
               r_db_cnt <= '0;
            end else if (r_db_cnt == SCW'(DB_SAMPLES - 1)) begin
               r_db_level <= r_btn_sync[1];
               r_db_cnt   <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end
         inst_vld <= w_rise;
         if (w_rise) inst_wd <= r_sw_s2;
      end
   end

   assign w_op     = inst_wd[OP_HI:OP_LO];
   assign w_ra     = inst_wd[RA_HI:RA_LO];
   assign w_rb     = inst_wd[RB_HI:RB_LO];
   assign w_rc     = inst_wd[RC_HI:RC_LO];
   assign w_immd   = inst_wd[IMM_HI:IMM_LO];
   assign w_ra_val = r_regs[w_ra];
   assign w_sum    = r_regs[w_rb] + r_regs[w_rc];
   assign w_prod   = r_regs[w_rb] * r_regs[w_rc];

   always_comb begin
      w_result = w_ra_val;
      case (w_op)
         OP_PUSH: w_result = {w_ra_val[3:0], w_immd};
         OP_ADD:  w_result = w_sum;
         OP_MULT: w_result = w_prod;
         default: w_result = w_ra_val;
      endcase
   end

   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) begin
         for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
         r_led <= '0;
      end else if (inst_vld) begin
         r_led <= w_result;
         if (w_op != OP_SEND) r_regs[w_ra] <= w_result;
      end
   end

   assign w_send_go = inst_vld && (w_op == OP_SEND) && !w_send_busy;

`ifdef SEND_HEX_EN
   logic       r_hex_act;
   logic [2:0] r_hex_idx;
   logic [7:0] r_hex_val;
   logic [7:0] w_hex_byte;

   assign w_send_busy = r_hex_act;

   always_comb begin
      w_hex_byte = ASCII_LF;
      case (r_hex_idx)
         3'd0:    w_hex_byte = hex_ascii(r_hex_val[7:4]);
         3'd1:    w_hex_byte = hex_ascii(r_hex_val[3:0]);
         3'd2:    w_hex_byte = ASCII_CR;
         default: w_hex_byte = ASCII_LF;
      endcase
   end

   // Feed one byte per idle transmitter; stay busy until the LF frame has finished.
   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) begin
         r_hex_act <= 1'b0;
         r_hex_idx <= '0;
         r_hex_val <= '0;
         r_tx_vld  <= 1'b0;
         r_tx_byte <= '0;
      end else begin
         r_tx_vld <= 1'b0;
         if (w_send_go) begin
            r_hex_act <= 1'b1;
            r_hex_idx <= '0;
            r_hex_val <= w_ra_val;
         end else if (r_hex_act && !w_tx_busy && !r_tx_vld) begin
            if (r_hex_idx == 3'd4) begin
               r_hex_act <= 1'b0;
            end else begin
               r_tx_vld  <= 1'b1;
               r_tx_byte <= w_hex_byte;
               r_hex_idx <= r_hex_idx + 3'd1;
            end
         end
      end
   end
`else
   assign w_send_busy = w_tx_busy || r_tx_vld;

   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) begin
         r_tx_vld  <= 1'b0;
         r_tx_byte <= '0;
      end else begin
         r_tx_vld <= w_send_go;
         if (w_send_go) r_tx_byte <= w_ra_val;
      end
   end
`endif

   uart_tx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart_tx (
      .i_clk   (clk),
      .i_rst_n (btnR),
      .i_vld   (r_tx_vld),
      .i_data  (r_tx_byte),
      .o_busy  (w_tx_busy),
      .o_tx    (RsTx)
   );

endmodule

// File: tb/tb_basys3_top.sv
// Directed bench for basys3_top with scaled timing (40 clocks per UART bit, 10-clock debounce tick).
module tb_basys3_top;

   localparam int unsigned BIT_T = 400;

   typedef struct {
      logic [7:0] inst;
      logic [7:0] exp_led;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       btnR = 1'b1;
   logic       btnS = 1'b0;
   logic       RsRx = 1'b1;
   logic [7:0] sw = '0;
   logic       RsTx;
   logic [7:0] led;

   int unsigned total = 0, passed = 0;
   int unsigned vld_count = 0, cyc = 0, vld_cyc = 0, fall_cyc = 0, rx_frame_err = 0;
   logic [7:0] last_wd = '0;
   logic       prev_tx = 1'b1;
   bit         rx_en = 1'b0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   basys3_top #(
      .CLK_HZ     (400),
      .BAUD       (10),
      .DB_TICK    (10),
      .DB_SAMPLES (2)
   ) dut (
      .clk  (clk),
      .btnR (btnR),
      .sw   (sw),
      .btnS (btnS),
      .RsRx (RsRx),
      .RsTx (RsTx),
      .led  (led)
   );

   initial forever #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (dut.inst_vld) begin
         vld_count++;
         last_wd = dut.inst_wd;
         vld_cyc = cyc;
      end
      if (prev_tx && !RsTx && fall_cyc < vld_cyc) fall_cyc = cyc;
      prev_tx = RsTx;
   end

   initial begin
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge RsTx);
         if (rx_en) begin
            #(BIT_T / 2);
            if (RsTx == 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  #(BIT_T);
                  b[i] = RsTx;
               end
               #(BIT_T);
               if (RsTx !== 1'b1) rx_frame_err++;
               rx_q.push_back(b);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic model_send(input logic [7:0] v);
`ifdef SEND_HEX_EN
      string hexs;
      hexs = "0123456789ABCDEF";
      exp_q.push_back(hexs[v[7:4]]);
      exp_q.push_back(hexs[v[3:0]]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`else
      exp_q.push_back(v);
`endif
   endtask

   task automatic check_rx(input string name);
      check({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check(name, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic press(input logic [7:0] inst, input logic [7:0] exp_led, input string name);
      int unsigned n0;
      n0 = vld_count;
      @(negedge clk);
      sw = inst;
      repeat (4) @(negedge clk);
      btnS = 1'b1;
      for (int i = 0; i < 100 && vld_count == n0; i++) @(negedge clk);
      repeat (40) @(negedge clk);
      btnS = 1'b0;
      repeat (40) @(negedge clk);
      check({name, "_vld_once"}, vld_count - n0, 1);
      check({name, "_inst_wd"}, last_wd, inst);
      check({name, "_led"}, led, exp_led);
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: time limit reached");
      $display("%0d/%0d checks passed", passed, total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[14];
      vecs[0]  = '{8'h1F, 8'h0F, "push_r1_f_a"};
      vecs[1]  = '{8'h1F, 8'hFF, "push_r1_f_b"};
      vecs[2]  = '{8'h22, 8'h02, "push_r2_2"};
      vecs[3]  = '{8'h46, 8'h01, "add_wrap"};
      vecs[4]  = '{8'h11, 8'hF1, "push_r1_1"};
      vecs[5]  = '{8'h10, 8'h10, "push_r1_0"};
      vecs[6]  = '{8'h22, 8'h22, "push_r2_2b"};
      vecs[7]  = '{8'h20, 8'h20, "push_r2_0"};
      vecs[8]  = '{8'hB6, 8'h00, "mult_trunc"};
      vecs[9]  = '{8'h6A, 8'h40, "add_alias"};
      vecs[10] = '{8'h79, 8'h50, "add_r3"};
      vecs[11] = '{8'h84, 8'h10, "mult_r0"};
      vecs[12] = '{8'h03, 8'h03, "push_r0_3"};
      vecs[13] = '{8'h0C, 8'h3C, "push_r0_c"};

      #1 btnR = 1'b0;
      repeat (10) @(negedge clk);
      btnR = 1'b1;
      @(negedge clk);
      check("reset_led", led, 8'h00);
      check("reset_tx_idle", RsTx, 1'b1);
      repeat (60) @(negedge clk);
      check("idle_no_vld", vld_count, 0);
      rx_en = 1'b1;

      // Bouncy press: toggling every clock, then a steady hold.
      sw = 8'h05;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         btnS = ~btnS;
         @(negedge clk);
      end
      btnS = 1'b1;
      repeat (60) @(negedge clk);
      btnS = 1'b0;
      repeat (40) @(negedge clk);
      check("bounce_vld_once", vld_count, 1);
      check("bounce_inst_wd", last_wd, 8'h05);
      check("bounce_led", led, 8'h05);

      foreach (vecs[i]) press(vecs[i].inst, vecs[i].exp_led, vecs[i].name);

      model_send(8'h3C);
      press(8'hC0, 8'h3C, "send_r0");
      check("tx_start_lat", (fall_cyc > vld_cyc) && (fall_cyc - vld_cyc <= 3), 1);
      repeat (2000) @(negedge clk);
      check_rx("send_r0_bytes");

      model_send(8'h3C);
      press(8'hC0, 8'h3C, "busy_first");
      press(8'hD0, 8'h10, "busy_drop");
      repeat (2000) @(negedge clk);
      check_rx("busy_bytes");

      model_send(8'h50);
      press(8'hF0, 8'h50, "send_r3");
      repeat (2000) @(negedge clk);
      check_rx("send_r3_bytes");
      check("rx_frame_err", rx_frame_err, 0);

      // Reset in the middle of a frame: line must go high at once.
      press(8'hE0, 8'h40, "send_abort");
      check("abort_midframe_low", RsTx, 1'b0);
      btnR = 1'b0;
      #1;
      check("abort_tx_high", RsTx, 1'b1);
      check("abort_led_clear", led, 8'h00);
      repeat (5) @(negedge clk);
      btnR = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_tx_high", RsTx, 1'b1);
      check("post_reset_led", led, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/basys3_top.md
# basys3_top

Top-level of a switch-programmed four-register calculator for the Basys3 board. Each debounced press of btnS executes the 8-bit instruction on sw[7:0] against a 4×8-bit register file. The led bus mirrors the last result. SEND transmits a register value over a UART (RsTx) to the host or to a behavioural UART model.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD, 1_000_000, UART bit rate (8N1).
- DB_TICK, 50_000, clock cycles between debounce samples (0.5 ms).
- DB_SAMPLES, 2, consecutive equal samples required to change the debounced level.

Ports:
- clk  in  1  system clock; one clock domain.
- btnR  in  1  reset; asynchronous, active-low.
- sw  in  8  instruction word.
- btnS  in  1  execute button (raw, bouncy).
- RsRx  in  1  UART receive; unused, tied off internally.
- RsTx  out  1  UART transmit; idles high.
- led  out  8  last result value.

## Operation
- Instruction decoding uses inst[7:6] as the opcode. ra=[5:4], rb=[3:2], rc=[1:0], immd=[3:0].
  - 00 PUSH: R[ra] <= {R[ra][3:0], immd}. Two PUSHes build a byte.
  - 01 ADD: R[ra] <= (R[rb] + R[rc]) mod 256.
  - 10 MULT: R[ra] <= low 8 bits of R[rb] × R[rc].
  - 11 SEND: transmit R[ra]. Bits [3:0] are ignored.
- Register aliasing is allowed, e.g. ra=rb=rc. Operands are read before the write.
- Debouncer:
  - btnS is double-flop synchronised.
  - The synchroniser output is sampled every DB_TICK cycles.
  - The debounced level changes after DB_SAMPLES consecutive equal samples.
- inst_vld (internal, named exactly so):
  - one-cycle pulse on the rising edge of the debounced level.
  - inst_wd (internal, named exactly so) captures synchronised sw in the same cycle.
  - Execution completes the cycle after inst_vld.
- led update:
  - PUSH, ADD and MULT set led to the value written.
  - SEND sets led to R[ra].
- UART TX: 8N1, LSB first, CLK_HZ/BAUD cycles per bit.
- A SEND issued while the transmitter is busy is dropped; its register and led effects still apply. There is no queue.
- Holding btnS produces one execution. Release requires DB_SAMPLES low samples.

## Timing
- Reset (btnR=0):
  - R0..R3=0, led=0, RsTx=1.
  - Debouncer level=0, inst_vld=0, transmitter idle.
  - Asserting reset mid-transmission aborts the frame; the line returns high immediately.
- Press-to-inst_vld latency: 2 sync cycles + (DB_SAMPLES−1)..DB_SAMPLES ticks, i.e. ≤1 ms with defaults.
- Register and led updates occur one cycle after inst_vld.
- The TX start bit begins within 2 cycles of SEND execution.
- Each byte lasts 10 bit periods (10 µs at defaults).
- Minimum supported btnS high and low time: DB_SAMPLES+1 ticks (1.5 ms).

## Configuration
- SEND_HEX_EN defined:
  - SEND emits four bytes: the ASCII uppercase hex high nibble, the low nibble, 0x0D, 0x0A.
  - The transmitter is busy until all four are sent.
- SEND_HEX_EN undefined: SEND emits the single raw byte R[ra].

## Structure
- Package basys3_calc_pkg holds:
  - opcode localparams OP_PUSH=2'b00, OP_ADD=2'b01, OP_MULT=2'b10, OP_SEND=2'b11;
  - instruction field slice constants;
  - the ASCII CR/LF constants.
- One sub-module, uart_tx: byte-wide valid/busy interface, parameters CLK_HZ and BAUD.
- Debounce, decode, register file and hex sequencer stay in the top.

## Test plan
- Reset then idle: btnR low 1 µs, then high → led=00000000, RsTx=1, no inst_vld for 1.5 ms.
- Bouncy press: sw=0x05 (PUSH R0,5); btnS toggled every 50 µs for 0.3 ms, then held 3 ms → exactly one inst_vld, inst_wd=0x05, led=0x05.
- ADD wrap: PUSH R1,F; PUSH R1,F (R1=0xFF); PUSH R2,2; ADD {01,00,01,10} → R0=0x01, led=00000001.
- MULT truncation: R1=0x10, R2=0x20; MULT R3=R1×R2 → R3=0x00, led=0x00.
- SEND with SEND_HEX_EN: R0=0x3C; SEND R0 (0xC0) → RsTx bytes 0x33, 0x43, 0x0D, 0x0A at 1 Mbaud; without SEND_HEX_EN → single byte 0x3C.
- Busy drop: second SEND 0.5 µs after the first (forced via inst_vld) → only the first frame transmitted; led still updated.
